// File: rtl/mandelbrot_frame_scheduler.sv
// Frame sequencer for one mandelbrot pixel engine: shadows the frame config, issues one run per pixel
// and streams the results through a small FWFT FIFO. Define MANDELBROT_PERF_EN to add frame_cycles.

module mandelbrot_frame_scheduler #(
    parameter int BITWIDTH   = 10,
    parameter int CTRWIDTH   = 7,
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 4,
    parameter int PERF_WIDTH = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic                auto_restart,
    input  logic [BITWIDTH-1:0] cfg_cr_offset,
    input  logic [BITWIDTH-1:0] cfg_ci_offset,
    input  logic [1:0]          cfg_scaling,
    input  logic [CTRWIDTH-1:0] cfg_max_ctr,
    input  logic [1:0]          cfg_ctr_select,
    output logic                eng_reset,
    output logic                eng_run,
    input  logic                eng_running,
    input  logic                eng_finished,
    input  logic [3:0]          eng_ctr,
    output logic [BITWIDTH-1:0] eng_cr_offset,
    output logic [BITWIDTH-1:0] eng_ci_offset,
    output logic [1:0]          eng_scaling,
    output logic [CTRWIDTH-1:0] eng_max_ctr,
    output logic [1:0]          eng_ctr_select,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [3:0]          pix_data,
    output logic                pix_first,
    output logic                pix_last,
    output logic                busy,
    output logic [7:0]          frame_count,
    output logic                err
`ifdef MANDELBROT_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0] frame_cycles
`endif
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (PERF_WIDTH < 1) begin : g_bad_perf
        $error("PERF_WIDTH must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE
    } state_e;

    typedef struct packed {
        logic       first;
        logic       last;
        logic [3:0] ctr;
    } pix_t;

    state_e                state_q, state_d;
    logic [BITWIDTH-1:0]   cr_q, ci_q;
    logic [1:0]            scaling_q, ctr_select_q;
    logic [CTRWIDTH-1:0]   max_ctr_q;
    logic [PW-1:0]         pix_cnt_q, pix_cnt_d;
    logic [7:0]            frame_cnt_q;
    logic                  err_q, err_d;
    logic                  eng_reset_q;
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    pix_t                  mem_q [FIFO_DEPTH];
    pix_t                  head;

    logic latch, clr_err, push, pop, frame_end, is_last;

    assign is_last = (pix_cnt_q == LAST_PIX);
    assign pop     = pix_valid & pix_ready;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        latch     = 1'b0;
        clr_err   = 1'b0;
        eng_run   = 1'b0;
        push      = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    latch   = 1'b1;
                    clr_err = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: state_d = S_ISSUE;
            S_ISSUE: begin
                // Only one pixel is ever in flight, so a free slot now is still free at its push.
                if (count_q < CW'(FIFO_DEPTH)) begin
                    eng_run = 1'b1;
                    state_d = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (eng_running) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!eng_running) begin
                    push = 1'b1;
                    if (is_last) begin
                        frame_end = 1'b1;
                        if (auto_restart) begin
                            latch   = 1'b1;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + PW'(1);
                        state_d   = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (latch) pix_cnt_d = '0;
    end

    always_comb begin
        err_d = err_q;
        if (clr_err)                               err_d = 1'b0;
        else if (push && (eng_finished != is_last)) err_d = 1'b1;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cr_q         <= '0;
            ci_q         <= '0;
            scaling_q    <= '0;
            max_ctr_q    <= '0;
            ctr_select_q <= '0;
            pix_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            err_q        <= 1'b0;
            eng_reset_q  <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            err_q       <= err_d;
            eng_reset_q <= 1'b0;
            count_q     <= count_d;
            if (latch) begin
                cr_q         <= cfg_cr_offset;
                ci_q         <= cfg_ci_offset;
                scaling_q    <= cfg_scaling;
                max_ctr_q    <= cfg_max_ctr;
                ctr_select_q <= cfg_ctr_select;
            end
            if (frame_end) frame_cnt_q <= frame_cnt_q + 8'd1;
            if (push)      wr_ptr_q    <= wr_ptr_q + AW'(1);
            if (pop)       rd_ptr_q    <= rd_ptr_q + AW'(1);
        end
    end

    // NOTE: the pixel array has no reset; count_q alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{first: (pix_cnt_q == '0), last: is_last, ctr: eng_ctr};
    end

    assign head           = mem_q[rd_ptr_q];
    assign pix_valid      = (count_q != '0);
    assign pix_data       = head.ctr;
    assign pix_first      = head.first;
    assign pix_last       = head.last;
    assign busy           = (state_q != S_IDLE);
    assign frame_count    = frame_cnt_q;
    assign err            = err_q;
    assign eng_reset      = eng_reset_q;
    assign eng_cr_offset  = cr_q;
    assign eng_ci_offset  = ci_q;
    assign eng_scaling    = scaling_q;
    assign eng_max_ctr    = max_ctr_q;
    assign eng_ctr_select = ctr_select_q;

`ifdef MANDELBROT_PERF_EN
    // frame_cycles reports busy cycles from the LOAD cycle through the frame-end cycle inclusive.
    logic [PERF_WIDTH-1:0] cyc_q, cyc_inc, frame_cycles_q;

    assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + PERF_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q          <= '0;
            frame_cycles_q <= '0;
        end else begin
            if (latch)     cyc_q <= '0;
            else if (busy) cyc_q <= cyc_inc;
            if (frame_end) frame_cycles_q <= cyc_inc;
        end
    end

    assign frame_cycles = frame_cycles_q;
`endif

endmodule

// File: tb/tb_mandelbrot_frame_scheduler.sv
// Directed bench for mandelbrot_frame_scheduler on a 4x3 frame with a stub engine (3-cycle busy,
// pixel value = (index*3 + cr_offset[3:0]) mod 16). Frame_cycles is checked when MANDELBROT_PERF_EN is set.

module tb_mandelbrot_frame_scheduler;

    localparam int NP = 12;

    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic       auto_restart;
    logic [9:0] cfg_cr_offset;
    logic [9:0] cfg_ci_offset;
    logic [1:0] cfg_scaling;
    logic [6:0] cfg_max_ctr;
    logic [1:0] cfg_ctr_select;
    logic       eng_reset;
    logic       eng_run;
    logic       eng_running;
    logic       eng_finished;
    logic [3:0] eng_ctr;
    logic [9:0] eng_cr_offset;
    logic [9:0] eng_ci_offset;
    logic [1:0] eng_scaling;
    logic [6:0] eng_max_ctr;
    logic [1:0] eng_ctr_select;
    logic       pix_valid;
    logic       pix_ready;
    logic [3:0] pix_data;
    logic       pix_first;
    logic       pix_last;
    logic       busy;
    logic [7:0] frame_count;
    logic       err;
`ifdef MANDELBROT_PERF_EN
    logic [23:0] frame_cycles;
`endif

    mandelbrot_frame_scheduler #(
        .BITWIDTH(10), .CTRWIDTH(7), .WIDTH(4), .HEIGHT(3), .FIFO_DEPTH(4), .PERF_WIDTH(24)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .auto_restart(auto_restart),
        .cfg_cr_offset(cfg_cr_offset), .cfg_ci_offset(cfg_ci_offset), .cfg_scaling(cfg_scaling),
        .cfg_max_ctr(cfg_max_ctr), .cfg_ctr_select(cfg_ctr_select),
        .eng_reset(eng_reset), .eng_run(eng_run), .eng_running(eng_running),
        .eng_finished(eng_finished), .eng_ctr(eng_ctr),
        .eng_cr_offset(eng_cr_offset), .eng_ci_offset(eng_ci_offset), .eng_scaling(eng_scaling),
        .eng_max_ctr(eng_max_ctr), .eng_ctr_select(eng_ctr_select),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_first(pix_first), .pix_last(pix_last),
        .busy(busy), .frame_count(frame_count), .err(err)
`ifdef MANDELBROT_PERF_EN
        , .frame_cycles(frame_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stub engine, updated on the falling edge so the DUT sees stable inputs at each rising edge.
    int         stub_cnt;
    int         stub_idx;
    logic [3:0] stub_val;
    int         bad_finish_at = -1;

    always @(negedge clk) begin
        if (eng_reset) begin
            eng_running  = 1'b0;
            eng_finished = 1'b1;
            eng_ctr      = 4'd0;
            stub_cnt     = 0;
            stub_idx     = 0;
        end else if (stub_cnt != 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                eng_running  = 1'b0;
                eng_ctr      = stub_val;
                eng_finished = (stub_idx == NP - 1) || (stub_idx == bad_finish_at);
                stub_idx     = (stub_idx == NP - 1) ? 0 : stub_idx + 1;
            end
        end else if (eng_run) begin
            eng_running  = 1'b1;
            eng_finished = 1'b0;
            stub_cnt     = 3;
            stub_val     = 4'(stub_idx * 3 + int'(eng_cr_offset[3:0]));
        end
    end

    // Consumer: records every accepted pixel as {first, last, data}; also counts run pulses.
    logic [5:0] pop_q[$];
    int         run_cnt = 0;

    always @(negedge clk) begin
        if (eng_run) run_cnt++;
        if (pix_valid && pix_ready) pop_q.push_back({pix_first, pix_last, pix_data});
    end

    // pix_ready pattern: 0 = held low, 1 = held high, 2 = high one cycle in seven.
    int ready_mode = 1;
    int rcyc       = 0;

    always @(posedge clk) begin
        #1;
        rcyc++;
        case (ready_mode)
            0:       pix_ready = 1'b0;
            1:       pix_ready = 1'b1;
            default: pix_ready = (rcyc % 7 == 0);
        endcase
    end

    function automatic logic [5:0] exp_pix(input int i, input int nib);
        logic [3:0] v;
        v = 4'(i * 3 + nib);
        return {i == 0, i == NP - 1, v};
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic start_frame();
        @(posedge clk);
        #2 frame_start = 1'b1;
        @(posedge clk);
        #2 frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int frames);
        int cyc = 0;
        while (!(int'(frame_count) == frames && !busy && !pix_valid) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(cyc < 3000), 32'd1);
    endtask

    task automatic wait_runs(input string tag, input int base, input int n);
        int cyc = 0;
        while (run_cnt - base < n && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(cyc < 1000), 32'd1);
    endtask

    task automatic check_stream(input string tag, input int start, input int nib);
        logic [31:0] got;
        for (int i = 0; i < NP; i++) begin
            got = (start + i < pop_q.size()) ? 32'(pop_q[start + i]) : 32'hFFFF_FFFF;
            check($sformatf("%s_pix%0d", tag, i), got, 32'(exp_pix(i, nib)));
        end
    endtask

    initial begin
        int base;
        int rbase;
        logic run_seen;
        int cyc;

        rst_n          = 1'b1;
        frame_start    = 1'b0;
        auto_restart   = 1'b0;
        cfg_cr_offset  = 10'h3C0;
        cfg_ci_offset  = 10'h3E0;
        cfg_scaling    = 2'd1;
        cfg_max_ctr    = 7'd15;
        cfg_ctr_select = 2'd2;
        pix_ready      = 1'b0;

        // Reset values, and eng_reset release on the first edge after rst_n rises.
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_eng_run", 32'(eng_run), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_eng_reset", 32'(eng_reset), 32'd1);
        check("rst_cr_shadow", 32'(eng_cr_offset), 32'd0);
`ifdef MANDELBROT_PERF_EN
        check("rst_frame_cycles", 32'(frame_cycles), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("eng_reset_held", 32'(eng_reset), 32'd1);
        @(posedge clk);
        #1 check("eng_reset_cleared", 32'(eng_reset), 32'd0);

        // 1: full frame with an always-ready consumer.
        ready_mode = 1;
        base = pop_q.size();
        start_frame();
        check("t1_load_busy", 32'(busy), 32'd1);
        check("t1_cr_shadow", 32'(eng_cr_offset), 32'h3C0);
        check("t1_ci_shadow", 32'(eng_ci_offset), 32'h3E0);
        check("t1_scaling", 32'(eng_scaling), 32'd1);
        check("t1_max_ctr", 32'(eng_max_ctr), 32'd15);
        check("t1_ctr_select", 32'(eng_ctr_select), 32'd2);
        wait_done("t1_done", 1);
        check("t1_count", pop_q.size() - base, NP);
        check_stream("t1", base, 0);
        check("t1_frame_count", 32'(frame_count), 32'd1);
        check("t1_err", 32'(err), 32'd0);
`ifdef MANDELBROT_PERF_EN
        check("t1_frame_cycles", 32'(frame_cycles), 32'd49);
`endif

        // 2: stalled consumer fills the FIFO, then drains with nothing lost.
        do_reset();
        ready_mode = 0;
        base  = pop_q.size();
        rbase = run_cnt;
        start_frame();
        repeat (40) @(negedge clk);
        run_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (eng_run) run_seen = 1'b1;
        end
        check("t2_runs_when_full", run_cnt - rbase, 4);
        check("t2_no_run_while_full", 32'(run_seen), 32'd0);
        check("t2_valid", 32'(pix_valid), 32'd1);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_head_stable", {26'd0, pix_first, pix_last, pix_data}, 32'(exp_pix(0, 0)));
        ready_mode = 1;
        wait_done("t2_done", 1);
        check("t2_count", pop_q.size() - base, NP);
        check_stream("t2", base, 0);

        // 3: slow consumer lets pushes and pops coincide.
        do_reset();
        ready_mode = 2;
        base = pop_q.size();
        start_frame();
        wait_done("t3_done", 1);
        check("t3_count", pop_q.size() - base, NP);
        check_stream("t3", base, 0);

        // 4: auto restart; a mid-frame cfg change only reaches the next frame.
        do_reset();
        ready_mode   = 1;
        auto_restart = 1'b1;
        base  = pop_q.size();
        rbase = run_cnt;
        start_frame();
        wait_runs("t4_reach_pix5", rbase, 6);
        cfg_cr_offset = 10'h3C5;
        cyc = 0;
        while (frame_count != 8'd1 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("t4_frame1_end", 32'(cyc < 1000), 32'd1);
        check("t4_no_idle_gap", 32'(busy), 32'd1);
        check("t4_new_cr_in_load", 32'(eng_cr_offset), 32'h3C5);
        auto_restart = 1'b0;
        wait_done("t4_done", 2);
        check("t4_count", pop_q.size() - base, 2 * NP);
        check_stream("t4_f1", base, 0);
        check_stream("t4_f2", base + NP, 5);
        check("t4_frame_count", 32'(frame_count), 32'd2);
`ifdef MANDELBROT_PERF_EN
        check("t4_frame_cycles", 32'(frame_cycles), 32'd49);
`endif

        // 5: engine reports finished early, so err sets and stays set.
        cfg_cr_offset = 10'h3C0;
        bad_finish_at = 3;
        start_frame();
        wait_done("t5_done", 3);
        check("t5_err_sticky", 32'(err), 32'd1);

        // 6: accepted frame_start clears err; reset mid-frame aborts everything.
        rbase = run_cnt;
        start_frame();
        check("t6_err_cleared", 32'(err), 32'd0);
        wait_runs("t6_reach_pix5", rbase, 6);
        check("t6_err_set_again", 32'(err), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_pix_valid", 32'(pix_valid), 32'd0);
        check("t6_eng_run", 32'(eng_run), 32'd0);
        check("t6_frame_count", 32'(frame_count), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        check("t6_eng_reset", 32'(eng_reset), 32'd1);
        check("t6_max_ctr_shadow", 32'(eng_max_ctr), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        bad_finish_at = -1;
        base = pop_q.size();
        start_frame();
        wait_done("t6_done", 1);
        check("t6_count", pop_q.size() - base, NP);
        check_stream("t6", base, 0);
        check("t6_err_final", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
